stream_pack_out: RTL

STREAM_PACK_OUT -- requirements
Module: stream_pack_out

---
 rtl/stream_pack_out.sv | 112 +++++++++++
 1 files changed

// File: rtl/stream_pack_out.sv
// Packs a D_W element stream into D_W_ACC-bit words, flushing a short word at the
// end of each DIM1*DIM2 matrix. Optional macro STREAM_PACK_LAST_CHECK_EN adds in_tlast checking.
module stream_pack_lane #(
  parameter int D_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           we,
  input  logic [D_W-1:0] d,
  output logic [D_W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   q <= '0;
    else if (clr) q <= '0;
    else if (we)  q <= d;
  end
endmodule

module stream_pack_out #(
  parameter int D_W          = 8,
  parameter int D_W_ACC      = 32,
  parameter int MATRIXSIZE_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [D_W-1:0]          in_tdata,
  input  logic                    in_tvalid,
  output logic                    in_tready,
  input  logic                    in_tlast,
  output logic [D_W_ACC-1:0]      out_tdata,
  output logic                    out_tvalid,
  input  logic                    out_tready,
  output logic                    out_tlast,
  input  logic [MATRIXSIZE_W-1:0] DIM1,
  input  logic [MATRIXSIZE_W-1:0] DIM2,
  output logic                    done,
  output logic                    err_last
);
  localparam int PACK   = D_W_ACC / D_W;
  localparam int LANE_W = $clog2(PACK);
  localparam int CNT_W  = 2 * MATRIXSIZE_W;

  logic [PACK-1:0][D_W-1:0] lane_q, word_nxt;
  logic [LANE_W-1:0]        lane;
  logic [CNT_W-1:0]         k, n_q, n_dim, n_new, n_eff;
  logic                     accept, last_elem, word_done;

  assign in_tready = !out_tvalid || out_tready;
  assign accept    = in_tvalid && in_tready;
  assign done      = out_tvalid && out_tready && out_tlast;

  // N is sampled on element 0 only; an empty matrix behaves as one element
  assign n_dim     = CNT_W'(DIM1) * CNT_W'(DIM2);
  assign n_new     = (n_dim == '0) ? CNT_W'(1) : n_dim;
  assign n_eff     = (k == '0) ? n_new : n_q;
  assign last_elem = (k == n_eff - CNT_W'(1));
  assign word_done = (lane == LANE_W'(PACK - 1)) || last_elem;

  // Storage is cleared whenever a word completes, so lanes above the
  // current one are already zero when a short word is flushed.
  for (genvar i = 0; i < PACK; i++) begin : g_lane
    stream_pack_lane #(.D_W(D_W)) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (accept && word_done),
      .we   (accept && !word_done && (lane == LANE_W'(i))),
      .d    (in_tdata),
      .q    (lane_q[i])
    );
    assign word_nxt[i] = (lane == LANE_W'(i)) ? in_tdata : lane_q[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane <= '0;
      k    <= '0;
      n_q  <= '0;
    end else if (accept) begin
      if (k == '0) n_q <= n_new;
      lane <= word_done ? '0 : lane + LANE_W'(1);
      k    <= last_elem ? '0 : k + CNT_W'(1);
    end
  end

  // Loading while the held word is being taken gives one word per PACK inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_tdata  <= '0;
      out_tvalid <= 1'b0;
      out_tlast  <= 1'b0;
    end else if (accept && word_done) begin
      out_tdata  <= D_W_ACC'(word_nxt);
      out_tvalid <= 1'b1;
      out_tlast  <= last_elem;
    end else if (out_tready) begin
      out_tvalid <= 1'b0;
      out_tlast  <= 1'b0;
    end
  end

`ifdef STREAM_PACK_LAST_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  err_last <= 1'b0;
    else if (accept && (in_tlast != last_elem)) err_last <= 1'b1;
  end
`else
  logic unused_tlast;
  assign unused_tlast = in_tlast;
  assign err_last     = 1'b0;
`endif
endmodule
